// File: rtl/note_key_pkg.sv
// Shared note/key definitions for the key transmitter and the LED note decoder:
// note count, ASCII key table, index->code lookup and UART framer state encoding.
package note_key_pkg;

  localparam int NOTE_COUNT     = 12;
  localparam int UART_DATA_BITS = 8;

  localparam logic [7:0] KEY_C  = 8'h7A;  // z
  localparam logic [7:0] KEY_CS = 8'h73;  // s
  localparam logic [7:0] KEY_D  = 8'h78;  // x
  localparam logic [7:0] KEY_DS = 8'h64;  // d
  localparam logic [7:0] KEY_E  = 8'h63;  // c
  localparam logic [7:0] KEY_F  = 8'h76;  // v
  localparam logic [7:0] KEY_FS = 8'h67;  // g
  localparam logic [7:0] KEY_G  = 8'h62;  // b
  localparam logic [7:0] KEY_GS = 8'h68;  // h
  localparam logic [7:0] KEY_A  = 8'h6E;  // n
  localparam logic [7:0] KEY_AS = 8'h6A;  // j
  localparam logic [7:0] KEY_B  = 8'h6D;  // m

  // Lowercase to uppercase distance in ASCII
  localparam logic [7:0] KEY_CASE_OFFSET = 8'h20;

  typedef logic [NOTE_COUNT-1:0] noteMask_t;
  typedef logic [3:0]            noteIdx_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } txState_t;

  function automatic logic [7:0] noteToKey(input noteIdx_t idx);
    logic [7:0] key;
    case (idx)
      4'd0:    key = KEY_C;
      4'd1:    key = KEY_CS;
      4'd2:    key = KEY_D;
      4'd3:    key = KEY_DS;
      4'd4:    key = KEY_E;
      4'd5:    key = KEY_F;
      4'd6:    key = KEY_FS;
      4'd7:    key = KEY_G;
      4'd8:    key = KEY_GS;
      4'd9:    key = KEY_A;
      4'd10:   key = KEY_AS;
      4'd11:   key = KEY_B;
      default: key = 8'h00;
    endcase
    return key;
  endfunction

  // Lowest set index wins, so C has the highest priority
  function automatic noteIdx_t lowestNote(input noteMask_t mask);
    noteIdx_t idx;
    idx = '0;
    for (int i = NOTE_COUNT - 1; i >= 0; i--) begin
      if (mask[i]) idx = noteIdx_t'(i);
    end
    return idx;
  endfunction

  function automatic noteMask_t noteBit(input noteIdx_t idx);
    return noteMask_t'(1) << idx;
  endfunction

endpackage

// File: rtl/note_key_tx_if.sv
// Key-input / serial-output bundle of the note key transmitter.
interface note_key_tx_if;
  import note_key_pkg::*;

  noteMask_t   inNotes;
  logic        outTx;
  logic        outBusy;
  logic [7:0]  outCode;

  modport master (output inNotes, input outTx, input outBusy, input outCode);
  modport slave  (input inNotes, output outTx, output outBusy, output outCode);
endinterface

// File: rtl/note_key_tx_uart_tx_core.sv
// UART 8N1 framer: start bit, 8 data bits LSB first, stop bit, CLKS_PER_BIT clocks each.
module uart_tx_core
  import note_key_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      inStart,
  input  logic [UART_DATA_BITS-1:0] inData,
  output logic                      outTx,
  output logic                      outBusy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  txState_t                  state;
  logic [CNT_W-1:0]          bitTimer;
  logic [2:0]                bitIdx;
  logic [UART_DATA_BITS-1:0] shiftReg;
  logic                      bitEnd;

  assign bitEnd = (bitTimer == CNT_LAST);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state    <= TX_IDLE;
      bitTimer <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      outTx    <= 1'b1;
      outBusy  <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          bitTimer <= '0;
          bitIdx   <= '0;
          outTx    <= 1'b1;
          outBusy  <= 1'b0;
          if (inStart) begin
            shiftReg <= inData;
            state    <= TX_START;
            outTx    <= 1'b0;
            outBusy  <= 1'b1;
          end
        end
        TX_START: begin
          bitTimer <= bitEnd ? '0 : bitTimer + 1'b1;
          if (bitEnd) begin
            state    <= TX_DATA;
            outTx    <= shiftReg[0];
            shiftReg <= shiftReg >> 1;
            bitIdx   <= '0;
          end
        end
        TX_DATA: begin
          bitTimer <= bitEnd ? '0 : bitTimer + 1'b1;
          if (bitEnd) begin
            if (bitIdx == 3'd7) begin
              state <= TX_STOP;
              outTx <= 1'b1;
            end else begin
              bitIdx   <= bitIdx + 1'b1;
              outTx    <= shiftReg[0];
              shiftReg <= shiftReg >> 1;
            end
          end
        end
        TX_STOP: begin
          bitTimer <= bitEnd ? '0 : bitTimer + 1'b1;
          // One IDLE cycle always separates frames, even with work queued
          if (bitEnd) begin
            state   <= TX_IDLE;
            outBusy <= 1'b0;
          end
        end
        default: begin
          state   <= TX_IDLE;
          outTx   <= 1'b1;
          outBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/note_key_tx.sv
// Note key transmitter: synchronises key inputs, queues new presses and sends their ASCII
// codes over UART 8N1. Define NOTE_KEY_RELEASE_EN to also send key releases (uppercase codes).
module note_key_tx
  import note_key_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic          clk,
  input  logic          rstb,
  note_key_tx_if.slave  bus
);

  noteMask_t  s1, s2, prev;
  noteMask_t  rise;
  noteMask_t  pressPend, pressGrant;
  logic       startReq;
  logic [7:0] startCode;
  logic [7:0] codeReg;
  logic       txLine, txBusy;

`ifdef NOTE_KEY_RELEASE_EN
  noteMask_t  fall;
  noteMask_t  releasePend, releaseGrant;
  assign fall = prev & ~s2;
`endif

  assign rise = s2 & ~prev;

  // Arbiter: only acts while the framer sits in IDLE
  always_comb begin
    startReq   = 1'b0;
    pressGrant = '0;
    startCode  = 8'h00;
`ifdef NOTE_KEY_RELEASE_EN
    releaseGrant = '0;
`endif
    if (!txBusy) begin
      if (pressPend != '0) begin
        startReq   = 1'b1;
        pressGrant = noteBit(lowestNote(pressPend));
        startCode  = noteToKey(lowestNote(pressPend));
      end
`ifdef NOTE_KEY_RELEASE_EN
      else if (releasePend != '0) begin
        startReq     = 1'b1;
        releaseGrant = noteBit(lowestNote(releasePend));
        startCode    = noteToKey(lowestNote(releasePend)) - KEY_CASE_OFFSET;
      end
`endif
    end
  end

  // Sync stage, edge history and pending queues; a same-cycle rise beats the grant clear
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1        <= '0;
      s2        <= '0;
      prev      <= '0;
      pressPend <= '0;
      codeReg   <= 8'h00;
    end else begin
      s1        <= bus.inNotes;
      s2        <= s1;
      prev      <= s2;
      pressPend <= (pressPend & ~pressGrant) | rise;
      if (startReq) codeReg <= startCode;
    end
  end

`ifdef NOTE_KEY_RELEASE_EN
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) releasePend <= '0;
    else       releasePend <= (releasePend & ~releaseGrant) | fall;
  end
`endif

  uart_tx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) uTxCore (
    .clk     (clk),
    .rstb    (rstb),
    .inStart (startReq),
    .inData  (startCode),
    .outTx   (txLine),
    .outBusy (txBusy)
  );

  assign bus.outTx   = txLine;
  assign bus.outBusy = txBusy;
  assign bus.outCode = codeReg;

endmodule

// File: tb/tb_note_key_tx.sv
// Directed bench for note_key_tx at CLKS_PER_BIT=4; release frames are expected only
// when NOTE_KEY_RELEASE_EN is defined.
module tb_note_key_tx;

  localparam int CPB = 4;

  logic clk  = 1'b0;
  logic rstb = 1'b0;
  int   cyc  = 0;
  int   nTests = 0;
  int   nFail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  note_key_tx_if bus ();

  note_key_tx #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits (at negedges) for a start bit, then captures 40 cycles of line and busy
  task automatic getFrame(input int timeout, output logic [9:0] frame,
                          output int startCyc, output bit found);
    int   waited   = 0;
    int   busyCnt  = 0;
    bit   shapeBad = 1'b0;
    logic s;
    frame    = '0;
    startCyc = 0;
    found    = 1'b0;
    while (!found && waited < timeout) begin
      if (bus.outTx === 1'b0) found = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
    if (found) begin
      startCyc = cyc;
      for (int k = 0; k < 10 * CPB; k++) begin
        s = bus.outTx;
        if (bus.outBusy === 1'b1) busyCnt++;
        if (k % CPB == 0) frame[k / CPB] = s;
        else if (s !== frame[k / CPB]) shapeBad = 1'b1;
        @(negedge clk);
      end
      check("startBit", {31'd0, frame[0]}, 32'd0);
      check("stopBit", {31'd0, frame[9]}, 32'd1);
      check("bitShape", {31'd0, shapeBad}, 32'd0);
      check("busyCycles", busyCnt, 40);
      check("idleBusy", {31'd0, bus.outBusy}, 32'd0);
    end
  endtask

  task automatic releaseKeys(input string tag, input logic [11:0] keys,
                             input logic [7:0] up0, input logic [7:0] up1, input int n);
    logic [9:0] f;
    int         st;
    bit         found;
    bus.inNotes = bus.inNotes & ~keys;
`ifdef NOTE_KEY_RELEASE_EN
    for (int k = 0; k < n; k++) begin
      getFrame(80, f, st, found);
      check({tag, "_relFound"}, {31'd0, found}, 32'd1);
      check({tag, "_relCode"}, {24'd0, f[8:1]}, {24'd0, (k == 0) ? up0 : up1});
    end
`else
    getFrame(30, f, st, found);
    check({tag, "_noRelFrame"}, {31'd0, found}, 32'd0);
`endif
    repeat (4) @(negedge clk);
  endtask

  initial begin
    logic [9:0] f;
    int         st1, st2, lows;
    bit         found, foundA;

    bus.inNotes = '0;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, bus.outTx}, 32'd1);
    check("rst_busy", {31'd0, bus.outBusy}, 32'd0);
    check("rst_code", {24'd0, bus.outCode}, 32'h00);
    rstb = 1'b1;
    repeat (2) @(negedge clk);

    // Single press of C: latency and exact frame
    bus.inNotes = 12'h001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("lat_edge2_high", {31'd0, bus.outTx}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("lat_edge3_low", {31'd0, bus.outTx}, 32'd0);
    getFrame(5, f, st1, found);
    check("z_found", {31'd0, found}, 32'd1);
    check("z_frame", {22'd0, f}, 32'h2F4);
    check("z_code", {24'd0, bus.outCode}, 32'h7A);
    releaseKeys("z", 12'h001, 8'h5A, 8'h00, 1);

    // Two simultaneous presses: priority order and inter-frame gap
    bus.inNotes = 12'h804;
    getFrame(20, f, st1, found);
    check("xm_first_found", {31'd0, found}, 32'd1);
    check("xm_first_code", {24'd0, f[8:1]}, 32'h78);
    getFrame(5, f, st2, found);
    check("xm_second_found", {31'd0, found}, 32'd1);
    check("xm_second_code", {24'd0, f[8:1]}, 32'h6D);
    check("xm_outCode", {24'd0, bus.outCode}, 32'h6D);
    check("xm_gap", st2 - st1, 41);
    getFrame(60, f, st2, found);
    check("xm_noThird", {31'd0, found}, 32'd0);
    releaseKeys("xm", 12'h804, 8'h58, 8'h4D, 2);

    // Held key produces a single event
    bus.inNotes = 12'h010;
    getFrame(20, f, st1, found);
    check("hold_found", {31'd0, found}, 32'd1);
    check("hold_code", {24'd0, f[8:1]}, 32'h63);
    lows = 0;
    for (int k = 0; k < 150; k++) begin
      if (bus.outTx !== 1'b1) lows++;
      @(negedge clk);
    end
    check("hold_singleFrame", lows, 0);
    releaseKeys("hold", 12'h010, 8'h43, 8'h00, 1);

    // Press arriving mid-frame is queued and follows after one idle cycle
    bus.inNotes = 12'h001;
    fork
      getFrame(20, f, st1, foundA);
      begin
        repeat (15) @(negedge clk);
        bus.inNotes = 12'h081;
      end
    join
    check("mid_z_found", {31'd0, foundA}, 32'd1);
    check("mid_z_code", {24'd0, f[8:1]}, 32'h7A);
    getFrame(5, f, st2, found);
    check("mid_b_found", {31'd0, found}, 32'd1);
    check("mid_b_code", {24'd0, f[8:1]}, 32'h62);
    check("mid_b_gap", st2 - st1, 41);
    releaseKeys("mid", 12'h081, 8'h5A, 8'h42, 2);

    // Reset during data bit 3 aborts the frame and flushes queued presses
    bus.inNotes = 12'h001;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.outTx === 1'b0) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_frameStarted", {31'd0, found}, 32'd1);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      if (k == 3) bus.inNotes = 12'h003;
      if (k == 7) bus.inNotes = 12'h000;
    end
    check("rst_preBusy", {31'd0, bus.outBusy}, 32'd1);
    #1 rstb = 1'b0;
    #1;
    check("rstMid_tx", {31'd0, bus.outTx}, 32'd1);
    check("rstMid_busy", {31'd0, bus.outBusy}, 32'd0);
    check("rstMid_code", {24'd0, bus.outCode}, 32'h00);
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    getFrame(60, f, st1, found);
    check("rst_staysIdle", {31'd0, found}, 32'd0);
    check("rst_idleBusy", {31'd0, bus.outBusy}, 32'd0);

    // Press then release of A
    bus.inNotes = 12'h200;
    getFrame(20, f, st1, found);
    check("n_found", {31'd0, found}, 32'd1);
    check("n_code", {24'd0, f[8:1]}, 32'h6E);
    releaseKeys("n", 12'h200, 8'h4E, 8'h00, 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1);
  end

endmodule
